// File: rtl/coz_pkg.sv
// Writeback request type shared by the execution units and geri_yazma_birimi.
package coz_pkg;

    import sabitler_pkg::*;

    localparam int unsigned RD_GENISLIGI = $clog2(REGISTER_SAYISI);

    // One completed result waiting for the register-file write port
    typedef struct packed {
        logic [RD_GENISLIGI-1:0]     rd;
        logic [SOZCUK_GENISLIGI-1:0] veri;
        logic                        fp;
    } geri_yazma_istek_t;

endpackage

// File: rtl/sabitler_pkg.sv
// Processor-wide constants shared by every pipeline stage.
package sabitler_pkg;

    localparam int unsigned SOZCUK_GENISLIGI = 32;
    localparam int unsigned REGISTER_SAYISI  = 32;

endpackage

// File: rtl/oncelik_hakemi.sv
// Single-grant arbiter: search starts at isaretci_i and wraps modulo
// KAYNAK_SAYISI. With isaretci_i tied to 0 it is a plain lowest-index-wins
// priority encoder.
module oncelik_hakemi #(
    parameter  int unsigned KAYNAK_SAYISI = 4,
    localparam int unsigned ISARETCI_GEN  = (KAYNAK_SAYISI > 1) ? $clog2(KAYNAK_SAYISI) : 1
) (
    input  logic [KAYNAK_SAYISI-1:0] gecerli_i,
    input  logic [ISARETCI_GEN-1:0]  isaretci_i,
    output logic [KAYNAK_SAYISI-1:0] hak_o
);

    logic w_bulundu;

    // First valid source at or after the pointer gets the one-hot grant
    always_comb begin
        hak_o     = '0;
        w_bulundu = 1'b0;
        for (int unsigned k = 0; k < KAYNAK_SAYISI; k++) begin
            for (int unsigned j = 0; j < KAYNAK_SAYISI; j++) begin
                if (!w_bulundu && gecerli_i[j] &&
                    (j == ((32'(isaretci_i) + k) % KAYNAK_SAYISI))) begin
                    hak_o[j]  = 1'b1;
                    w_bulundu = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/geri_yazma_birimi.sv
// Writeback stage: arbitrates execution-unit results onto the single
// register-file write port, one registered write per cycle.
// GERI_YAZMA_RR_EN defined selects round-robin; otherwise fixed priority.
module geri_yazma_birimi
    import sabitler_pkg::*;
    import coz_pkg::*;
#(
    parameter int unsigned KAYNAK_SAYISI = 4
) (
    input  logic                                         clk_i,
    input  logic                                         rstn_i,
    input  logic [KAYNAK_SAYISI-1:0]                     kaynak_gecerli_i,
    output logic [KAYNAK_SAYISI-1:0]                     kaynak_hazir_o,
    input  logic [KAYNAK_SAYISI-1:0][RD_GENISLIGI-1:0]   kaynak_rd_i,
    input  logic [KAYNAK_SAYISI-1:0][SOZCUK_GENISLIGI-1:0] kaynak_veri_i,
    input  logic [KAYNAK_SAYISI-1:0]                     kaynak_fp_i,
    output logic [RD_GENISLIGI-1:0]                      rd_o,
    output logic [SOZCUK_GENISLIGI-1:0]                  rd_veri_o,
    output logic                                         rd_yaz_o,
    output logic                                         rd_fp_yaz_o,
    output logic                                         bosta_o
);

    localparam int unsigned ISARETCI_GEN = (KAYNAK_SAYISI > 1) ? $clog2(KAYNAK_SAYISI) : 1;

    geri_yazma_istek_t               w_istek [KAYNAK_SAYISI];
    geri_yazma_istek_t               w_secilen;
    logic [KAYNAK_SAYISI-1:0]        w_hak;
    logic [ISARETCI_GEN-1:0]         w_isaretci;
    logic                            w_transfer;
    logic                            w_x0_yazma;

    logic [RD_GENISLIGI-1:0]         r_rd;
    logic [SOZCUK_GENISLIGI-1:0]     r_veri;
    logic                            r_yaz;
    logic                            r_fp;

    // Gather the flat source ports into request structs
    always_comb begin
        for (int unsigned i = 0; i < KAYNAK_SAYISI; i++) begin
            w_istek[i].rd   = kaynak_rd_i[i];
            w_istek[i].veri = kaynak_veri_i[i];
            w_istek[i].fp   = kaynak_fp_i[i];
        end
    end

    oncelik_hakemi #(
        .KAYNAK_SAYISI(KAYNAK_SAYISI)
    ) u_hakem (
        .gecerli_i  (kaynak_gecerli_i),
        .isaretci_i (w_isaretci),
        .hak_o      (w_hak)
    );

    // No grant is offered while reset is held, so nothing is freed then
    assign kaynak_hazir_o = rstn_i ? w_hak : '0;
    assign w_transfer     = |(kaynak_gecerli_i & kaynak_hazir_o);

    // Select the granted request for the output register
    always_comb begin
        w_secilen = '0;
        for (int unsigned i = 0; i < KAYNAK_SAYISI; i++) begin
            if (w_hak[i]) begin
                w_secilen = w_istek[i];
            end
        end
    end

    // Integer x0 is architecturally zero: complete the handshake, suppress the write
    assign w_x0_yazma = !w_secilen.fp && (w_secilen.rd == '0);

    // Output register driving the register-file write port and bypass
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rd   <= '0;
            r_veri <= '0;
            r_yaz  <= 1'b0;
            r_fp   <= 1'b0;
        end else begin
            r_yaz <= w_transfer && !w_x0_yazma;
            if (w_transfer) begin
                r_rd   <= w_secilen.rd;
                r_veri <= w_secilen.veri;
                r_fp   <= w_secilen.fp;
            end
        end
    end

`ifdef GERI_YAZMA_RR_EN
    logic [ISARETCI_GEN-1:0] r_isaretci;
    logic [ISARETCI_GEN-1:0] w_hak_idx;

    // Encode the one-hot grant back to an index
    always_comb begin
        w_hak_idx = '0;
        for (int unsigned i = 0; i < KAYNAK_SAYISI; i++) begin
            if (w_hak[i]) begin
                w_hak_idx = ISARETCI_GEN'(i);
            end
        end
    end

    // Pointer moves to the slot after the grantee, only on a transfer
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_isaretci <= '0;
        end else if (w_transfer) begin
            r_isaretci <= (w_hak_idx == ISARETCI_GEN'(KAYNAK_SAYISI - 1)) ? '0
                                                                          : w_hak_idx + 1'b1;
        end
    end

    assign w_isaretci = r_isaretci;
`else
    assign w_isaretci = '0;
`endif

    assign rd_o        = r_rd;
    assign rd_veri_o   = r_veri;
    assign rd_yaz_o    = r_yaz;
    assign rd_fp_yaz_o = r_fp;
    assign bosta_o     = !(|kaynak_gecerli_i) && !r_yaz;

endmodule

// File: tb/tb_geri_yazma_birimi.sv
// Directed bench for geri_yazma_birimi; expectations follow GERI_YAZMA_RR_EN.
module tb_geri_yazma_birimi;

    logic             clk;
    logic             rstn;
    logic [3:0]       gecerli;
    logic [3:0]       hazir;
    logic [3:0][4:0]  k_rd;
    logic [3:0][31:0] k_veri;
    logic [3:0]       k_fp;
    logic [4:0]       rd;
    logic [31:0]      rd_veri;
    logic             rd_yaz;
    logic             rd_fp_yaz;
    logic             bosta;

    int n_vek;
    int n_hata;

    geri_yazma_birimi #(.KAYNAK_SAYISI(4)) dut (
        .clk_i            (clk),
        .rstn_i           (rstn),
        .kaynak_gecerli_i (gecerli),
        .kaynak_hazir_o   (hazir),
        .kaynak_rd_i      (k_rd),
        .kaynak_veri_i    (k_veri),
        .kaynak_fp_i      (k_fp),
        .rd_o             (rd),
        .rd_veri_o        (rd_veri),
        .rd_yaz_o         (rd_yaz),
        .rd_fp_yaz_o      (rd_fp_yaz),
        .bosta_o          (bosta)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kaynak;   // -1: no source valid
        logic [4:0]  rd;
        logic [31:0] veri;
        logic        fp;
        logic [3:0]  e_hazir;
        logic        e_yaz;
        logic [4:0]  e_rd;
        logic [31:0] e_veri;
        logic        e_fp;
    } vektor_t;

    vektor_t tablo [8];

    task automatic kontrol(input string ad, input logic [31:0] gercek, input logic [31:0] beklenen);
        n_vek++;
        if (gercek !== beklenen) begin
            n_hata++;
            $display("FAIL %s: got %h expected %h (t=%0t)", ad, gercek, beklenen, $time);
        end
    endtask

    task automatic kenar();
        @(posedge clk);
        #1;
    endtask

    task automatic temizle();
        gecerli = '0;
        k_rd    = '0;
        k_veri  = '0;
        k_fp    = '0;
    endtask

    task automatic sifirla();
        @(negedge clk);
        rstn = 1'b0;
        temizle();
        @(negedge clk);
        rstn = 1'b1;
        #1;
    endtask

    initial begin
        n_vek  = 0;
        n_hata = 0;

        tablo[0] = '{0, 5'd5, 32'hDEADBEEF, 1'b0, 4'b0001, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0};
        tablo[1] = '{-1, 5'd0, 32'h0, 1'b0, 4'b0000, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0};
        tablo[2] = '{3, 5'd0, 32'h12345678, 1'b0, 4'b1000, 1'b0, 5'd0, 32'h12345678, 1'b0};
        tablo[3] = '{3, 5'd0, 32'h3F800000, 1'b1, 4'b1000, 1'b1, 5'd0, 32'h3F800000, 1'b1};
        tablo[4] = '{1, 5'd31, 32'hFFFFFFFF, 1'b0, 4'b0010, 1'b1, 5'd31, 32'hFFFFFFFF, 1'b0};
        tablo[5] = '{2, 5'd7, 32'h00000000, 1'b1, 4'b0100, 1'b1, 5'd7, 32'h00000000, 1'b1};
        tablo[6] = '{2, 5'd0, 32'hA5A5A5A5, 1'b0, 4'b0100, 1'b0, 5'd0, 32'hA5A5A5A5, 1'b0};
        tablo[7] = '{0, 5'd1, 32'h00000001, 1'b0, 4'b0001, 1'b1, 5'd1, 32'h00000001, 1'b0};

        // Reset: outputs cleared and no grant even with every source valid
        rstn = 1'b0;
        temizle();
        gecerli = 4'b1111;
        #12;
        kontrol("reset_hazir", 32'(hazir), 32'h0);
        kontrol("reset_yaz", 32'(rd_yaz), 32'h0);
        kontrol("reset_rd", 32'(rd), 32'h0);
        kontrol("reset_veri", rd_veri, 32'h0);
        kontrol("reset_fp", 32'(rd_fp_yaz), 32'h0);
        gecerli = '0;
        #1;
        kontrol("reset_bosta", 32'(bosta), 32'h1);
        @(negedge clk);
        rstn = 1'b1;
        kenar();

        // Table vectors: one transfer per entry, checked in the following cycle
        for (int i = 0; i < 8; i++) begin
            temizle();
            if (tablo[i].kaynak >= 0) begin
                gecerli[tablo[i].kaynak] = 1'b1;
                k_rd[tablo[i].kaynak]    = tablo[i].rd;
                k_veri[tablo[i].kaynak]  = tablo[i].veri;
                k_fp[tablo[i].kaynak]    = tablo[i].fp;
            end
            #1;
            kontrol($sformatf("v%0d_hazir", i), 32'(hazir), 32'(tablo[i].e_hazir));
            if (tablo[i].kaynak >= 0)
                kontrol($sformatf("v%0d_bosta_mesgul", i), 32'(bosta), 32'h0);
            kenar();
            temizle();
            #1;
            kontrol($sformatf("v%0d_yaz", i), 32'(rd_yaz), 32'(tablo[i].e_yaz));
            kontrol($sformatf("v%0d_rd", i), 32'(rd), 32'(tablo[i].e_rd));
            kontrol($sformatf("v%0d_veri", i), rd_veri, tablo[i].e_veri);
            kontrol($sformatf("v%0d_fp", i), 32'(rd_fp_yaz), 32'(tablo[i].e_fp));
            kontrol($sformatf("v%0d_bosta", i), 32'(bosta), 32'(!tablo[i].e_yaz));
        end

        // Contention: all four valid continuously from pointer 0
        sifirla();
        for (int s = 0; s < 4; s++) begin
            k_rd[s]   = 5'(10 + s);
            k_veri[s] = 32'h100 + 32'(s);
        end
        gecerli = 4'b1111;
        for (int c = 0; c < 5; c++) begin
`ifdef GERI_YAZMA_RR_EN
            int g = c % 4;
`else
            int g = 0;
`endif
            #1;
            kontrol($sformatf("yaris%0d_hazir", c), 32'(hazir), 32'(1) << g);
            kenar();
            kontrol($sformatf("yaris%0d_yaz", c), 32'(rd_yaz), 32'h1);
            kontrol($sformatf("yaris%0d_rd", c), 32'(rd), 32'(10 + g));
            kontrol($sformatf("yaris%0d_veri", c), rd_veri, 32'h100 + 32'(g));
        end

        // Stability: FPU (rd 7) waits two cycles behind ALU and MUL
        sifirla();
        k_rd[0] = 5'd2;  k_veri[0] = 32'h22222222;
        k_rd[1] = 5'd3;  k_veri[1] = 32'h33333333;
        k_rd[2] = 5'd7;  k_veri[2] = 32'h3F800000; k_fp[2] = 1'b1;
        gecerli = 4'b0111;
        #1;
        kontrol("kararli_hazir0", 32'(hazir), 32'h1);
        kenar();
        kontrol("kararli_rd0", 32'(rd), 32'd2);
        gecerli = 4'b0110;
        #1;
        kontrol("kararli_hazir1", 32'(hazir), 32'h2);
        kenar();
        kontrol("kararli_rd1", 32'(rd), 32'd3);
        gecerli = 4'b0100;
        #1;
        kontrol("kararli_hazir2", 32'(hazir), 32'h4);
        kenar();
        gecerli = 4'b0000;
        kontrol("kararli_yaz2", 32'(rd_yaz), 32'h1);
        kontrol("kararli_rd2", 32'(rd), 32'd7);
        kontrol("kararli_veri2", rd_veri, 32'h3F800000);
        kontrol("kararli_fp2", 32'(rd_fp_yaz), 32'h1);
        kenar();
        kontrol("kararli_tekrar_yok", 32'(rd_yaz), 32'h0);

        // Idle after a write: outputs hold, bosta rises when the write ends
        temizle();
        k_rd[1] = 5'd9; k_veri[1] = 32'hCAFEF00D; gecerli = 4'b0010;
        kenar();
        temizle();
        #1;
        kontrol("bos_yaz", 32'(rd_yaz), 32'h1);
        kontrol("bos_bosta_yazarken", 32'(bosta), 32'h0);
        for (int c = 0; c < 3; c++) begin
            kenar();
            kontrol($sformatf("bos%0d_bosta", c), 32'(bosta), 32'h1);
            kontrol($sformatf("bos%0d_yaz", c), 32'(rd_yaz), 32'h0);
            kontrol($sformatf("bos%0d_rd", c), 32'(rd), 32'd9);
            kontrol($sformatf("bos%0d_veri", c), rd_veri, 32'hCAFEF00D);
        end

        // Reset mid-stream while a write is on the port
        temizle();
        k_rd[0] = 5'd3; k_veri[0] = 32'h11; gecerli = 4'b0001;
        kenar();
        for (int s = 0; s < 4; s++) begin
            k_rd[s]   = 5'(20 + s);
            k_veri[s] = 32'h200 + 32'(s);
        end
        gecerli = 4'b1111;
        kontrol("sifir_oncesi_yaz", 32'(rd_yaz), 32'h1);
        #2;
        rstn = 1'b0;
        #1;
        kontrol("sifir_yaz", 32'(rd_yaz), 32'h0);
        kontrol("sifir_rd", 32'(rd), 32'h0);
        kontrol("sifir_veri", rd_veri, 32'h0);
        kontrol("sifir_fp", 32'(rd_fp_yaz), 32'h0);
        kontrol("sifir_hazir", 32'(hazir), 32'h0);
        kenar();
        kontrol("sifir_kenar_yaz", 32'(rd_yaz), 32'h0);
        #2;
        rstn = 1'b1;
        #1;
        kontrol("sonra_hazir0", 32'(hazir), 32'h1);
        kenar();
        kontrol("sonra_rd0", 32'(rd), 32'd20);
`ifdef GERI_YAZMA_RR_EN
        kontrol("sonra_hazir1", 32'(hazir), 32'h2);
        kenar();
        kontrol("sonra_rd1", 32'(rd), 32'd21);
`else
        kontrol("sonra_hazir1", 32'(hazir), 32'h1);
        kenar();
        kontrol("sonra_rd1", 32'(rd), 32'd20);
`endif
        temizle();
        kenar();

        $display("== %0d vectors applied, %0d miscompares ==", n_vek, n_hata);
        $finish;
    end

endmodule

// File: doc/geri_yazma_birimi.md
# geri_yazma_birimi

Writeback stage that collects completed results from the execution units (ALU, multiplier/divider, FPU, load unit) and serialises them onto the register file's single write port (rd index, data, write enable, FP-select). Each unit presents one result with a valid/ready handshake. One result is granted per cycle and registered, and the registered value drives the integer/FP register file directly. The same registered value is the writeback bypass source for decode.

## Interface
- KAYNAK_SAYISI, 4: number of result sources; index 0 = ALU, 1 = MUL/DIV, 2 = FPU, 3 = load.
- SOZCUK_GENISLIGI, REGISTER_SAYISI: taken from sabitler_pkg (32, 32).
- clk_i  in  1  clock; all state on rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- kaynak_gecerli_i  in  KAYNAK_SAYISI  per-source result valid.
- kaynak_hazir_o  out  KAYNAK_SAYISI  per-source grant/ready (one-hot or zero).
- kaynak_rd_i  in  KAYNAK_SAYISI x $clog2(REGISTER_SAYISI)  destination index per source.
- kaynak_veri_i  in  KAYNAK_SAYISI x SOZCUK_GENISLIGI  result data per source.
- kaynak_fp_i  in  KAYNAK_SAYISI  1 = destination is the FP file.
- rd_o  out  $clog2(REGISTER_SAYISI)  register-file write index.
- rd_veri_o  out  SOZCUK_GENISLIGI  register-file write data.
- rd_yaz_o  out  1  register-file write enable.
- rd_fp_yaz_o  out  1  write targets the FP file.
- bosta_o  out  1  no source valid and no write in flight.

## Operation
- Transfer on source i when kaynak_gecerli_i[i] && kaynak_hazir_o[i].
- Source rules:
  - A source holds valid, rd, data and fp stable until it is granted.
  - A source's valid must not depend on its ready.
- kaynak_hazir_o is combinational from the valid vector and the arbiter state.
  - At most one bit is set.
  - It is all-zero when no source is valid and while rstn_i is low.
- On a transfer, the output register loads rd, data and fp from the granted source. rd_yaz_o is set for the following cycle only.
- Integer write to x0 (fp = 0, rd = 0):
  - The handshake completes (the source is freed).
  - rd_yaz_o stays 0.
  - rd_o, rd_veri_o and rd_fp_yaz_o still load.
- An FP write to f0 is a normal write.
- No transfer in a cycle: next cycle rd_yaz_o = 0. rd_o, rd_veri_o and rd_fp_yaz_o hold their previous values.
- bosta_o = !(|kaynak_gecerli_i) && !rd_yaz_o.
- Arbitration is set by the macro (see Configuration). Each losing source keeps valid and is served in a later cycle.

## Timing
- Accept in cycle t; rd_yaz_o, rd_o and rd_veri_o are valid throughout t+1. The register file writes at the end of t+1, and the value is readable from the file in t+2.
- Throughput: one result per cycle. There is no back-pressure from the register file; the port always accepts.
- Back-to-back writes to the same rd in t and t+1: both are performed in order, and the later one wins.
- Reset values (asynchronous, immediate on rstn_i low): rd_o = 0, rd_veri_o = 0, rd_yaz_o = 0, rd_fp_yaz_o = 0, round-robin pointer = 0. bosta_o follows its equation.
- Reset mid-operation: a result granted in the reset cycle is lost, and no write is issued. Sources re-present after reset.

## Configuration
- GERI_YAZMA_RR_EN defined: round-robin arbitration.
  - A pointer holds the index after the last grantee, and the search starts at the pointer, wrapping modulo KAYNAK_SAYISI.
  - The pointer updates only on a transfer.
- GERI_YAZMA_RR_EN undefined: fixed priority; the lowest valid index wins. There is no pointer state.

## Structure
- In coz_pkg: typedef geri_yazma_istek_t, a struct of rd index, data and fp flag. The source ports are arrays of it internally.
- Widths come from the existing sabitler_pkg constants, with no local redefinitions.
- One sub-module, oncelik_hakemi:
  - Parameterised by KAYNAK_SAYISI.
  - Inputs: valid vector and pointer. Output: one-hot grant.
  - The pointer input is tied to 0 when the macro is undefined.
- Mux, output register and pointer live in geri_yazma_birimi.

## Test plan
- Single source: ALU valid with rd = 5, data = 0xDEADBEEF, fp = 0 at t -> hazir[0] = 1 at t. In t+1: rd_yaz_o = 1, rd_o = 5, rd_veri_o = 0xDEADBEEF, rd_fp_yaz_o = 0. rd_yaz_o = 0 at t+2.
- Integer x0 discard: load valid with rd = 0, fp = 0 -> hazir[3] = 1 and rd_yaz_o = 0 next cycle. The same case with fp = 1 -> rd_yaz_o = 1, rd_fp_yaz_o = 1.
- Contention, all four sources valid continuously:
  - RR build: grants go 0, 1, 2, 3, 0 on consecutive cycles, with four writes in four consecutive cycles.
  - Fixed-priority build: source 0 is granted every cycle, and the other sources stay pending.
- Stability: a losing FPU source holds rd = 7, data = 0x3F800000 for 2 cycles -> it is written with exactly those values once granted. No duplicate write.
- Reset mid-stream: assert rstn_i low between clock edges while rd_yaz_o = 1 -> all outputs are 0 immediately. After release, the RR pointer restarts at source 0.
- Idle: no valid for 3 cycles after a write -> bosta_o = 1 from the cycle rd_yaz_o drops. rd_o and rd_veri_o keep their last values.
